muldiv_iter: RTL

- Parametrised, multi-cycle RV M-extension execution unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU plus word (W) variants.
- Sits beside the combinational ALU in the EX stage. Replaces single-cycle multiply/divide with an iterative datapath behind a valid/ready handshake, so the pipeline stalls instead of closing timing through a 64-bit divider.
- Supports a synchronous flush for branch mispredict/trap kill.

---
 rtl/muldiv_iter.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV M-extension execution unit (MUL/MULH/MULHSU/MULHU/
// DIV/DIVU/REM/REMU plus the W variants). The unit sits beside the EX-stage ALU
// and uses a valid/ready handshake. The pipeline stalls while the unit iterates,
// so the 64-bit divider does not have to close timing in one cycle.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   flush            kills the in-flight op (synchronous, beats in_valid/out_ready)
//   in_valid/ready   request handshake; ready only in IDLE and not in reset
//   op, halfop       operation select; halfop = W variant (ignored when XLEN=32)
//   src1, src2       operands, latched on accept
//   out_valid/ready  result handshake; result holds until taken
//   result           XLEN-bit result (W results sign-extended from bit 31)
//
// Build option: define MULDIV_FAST_MUL_EN to compute multiplies with one
// combinational product at accept time (IDLE->DONE). Divide is the same in
// both builds.
module muldiv_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            halfop,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    localparam int              PW       = 2 * XLEN;
    localparam logic [6:0]      N_FULL   = 7'(XLEN);
    localparam logic [6:0]      N_WORD   = 7'd32;
    localparam logic            HAS_WORD = (XLEN == 64);
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] MIN_FULL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [PW-1:0]   PZERO    = {PW{1'b0}};
    localparam logic [PW-1:0]   PONE     = {{(PW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v;
        for (int i = 32; i < XLEN; i++) r[i] = v[31];
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v;
        for (int i = 32; i < XLEN; i++) r[i] = 1'b0;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] cneg(input logic n, input logic [XLEN-1:0] v);
        return n ? (~v + ONE) : v;
    endfunction

    function automatic logic [PW-1:0] cneg_p(input logic n, input logic [PW-1:0] v);
        return n ? (~v + PONE) : v;
    endfunction

    // Any W multiply returns the mulw result: low word, sign-extended.
    function automatic logic [XLEN-1:0] mul_pick(input logic [2:0] o, input logic w,
                                                 input logic [PW-1:0] p);
        logic [XLEN-1:0] r;
        if (w) r = sext32(p[XLEN-1:0]);
        else if (o[1:0] == 2'b00) r = p[XLEN-1:0];
        else r = p[PW-1:XLEN];
        return r;
    endfunction

    state_t          state_r;
    logic [2:0]      op_r;
    logic            word_r, neg_r;
    logic [6:0]      cnt_r;
    logic [PW-1:0]   prod_r, mcand_r;
    logic [XLEN-1:0] mplier_r, rem_r, quo_r, div_r, result_r;

    logic            word_s, s1_signed_s, s2_signed_s, sign1_s, sign2_s, neg_s;
    logic            div_zero_s, min_hit_s, div_ovf_s;
    logic [XLEN-1:0] ext1_s, ext2_s, mag1_s, mag2_s, bypass_raw_s, bypass_s;
`ifdef MULDIV_FAST_MUL_EN
    logic [PW-1:0]   fast_prod_s;
    logic [XLEN-1:0] fast_res_s;
`endif

    // Operand preparation at accept: extension, magnitudes, result sign, bypasses.
    always_comb begin
        word_s = halfop & HAS_WORD;
        case (op)
            3'b000, 3'b001, 3'b100, 3'b110: begin s1_signed_s = 1'b1; s2_signed_s = 1'b1; end
            3'b010:                         begin s1_signed_s = 1'b1; s2_signed_s = 1'b0; end
            default:                        begin s1_signed_s = 1'b0; s2_signed_s = 1'b0; end
        endcase
        if (word_s) begin
            ext1_s = s1_signed_s ? sext32(src1) : zext32(src1);
            ext2_s = s2_signed_s ? sext32(src2) : zext32(src2);
        end else begin
            ext1_s = src1;
            ext2_s = src2;
        end
        sign1_s = s1_signed_s & ext1_s[XLEN-1];
        sign2_s = s2_signed_s & ext2_s[XLEN-1];
        mag1_s  = cneg(sign1_s, ext1_s);
        mag2_s  = cneg(sign2_s, ext2_s);
        // rem takes the dividend's sign; everything else is the xor of both signs.
        neg_s   = (op[2] & op[1]) ? sign1_s : (sign1_s ^ sign2_s);
        div_zero_s = (ext2_s == ZERO);
        if (word_s) begin
            min_hit_s = (src1[31:0] == 32'h8000_0000) && (src2[31:0] == 32'hFFFF_FFFF);
        end else begin
            min_hit_s = (src1 == MIN_FULL) && (src2 == ONES);
        end
        div_ovf_s = min_hit_s & s1_signed_s;
        if (div_zero_s) begin
            bypass_raw_s = op[1] ? ext1_s : ONES;
        end else begin
            bypass_raw_s = op[1] ? ZERO : ext1_s;
        end
        bypass_s = word_s ? sext32(bypass_raw_s) : bypass_raw_s;
`ifdef MULDIV_FAST_MUL_EN
        fast_prod_s = {ZERO, mag1_s} * {ZERO, mag2_s};
        fast_res_s  = mul_pick(op, word_s, cneg_p(neg_s, fast_prod_s));
`endif
    end

    logic [6:0]      n_s;
    logic            last_s, take_s;
    logic [PW-1:0]   prod_nxt_s;
    logic [XLEN:0]   shift_s, trial_s;
    logic [XLEN-1:0] rem_nxt_s, mul_res_s, div_raw_s, div_res_s;

    // One shift-add / restoring-divide step and the final sign-corrected results.
    always_comb begin
        n_s        = word_r ? N_WORD : N_FULL;
        last_s     = (cnt_r == n_s);
        prod_nxt_s = prod_r + (mplier_r[0] ? mcand_r : PZERO);
        // The next dividend bit comes from the top of the active N-bit window.
        shift_s    = {rem_r, (word_r ? quo_r[31] : quo_r[XLEN-1])};
        trial_s    = shift_s - {1'b0, div_r};
        take_s     = ~trial_s[XLEN];
        rem_nxt_s  = take_s ? trial_s[XLEN-1:0] : shift_s[XLEN-1:0];
        mul_res_s  = mul_pick(op_r, word_r, cneg_p(neg_r, prod_r));
        div_raw_s  = op_r[1] ? cneg(neg_r, rem_r) : cneg(neg_r, quo_r);
        div_res_s  = word_r ? sext32(div_raw_s) : div_raw_s;
    end

    // Control FSM and datapath registers; flush and rst both win over handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            result_r <= ZERO;
            op_r     <= 3'b000;
            word_r   <= 1'b0;
            neg_r    <= 1'b0;
            cnt_r    <= 7'd0;
            prod_r   <= PZERO;
            mcand_r  <= PZERO;
            mplier_r <= ZERO;
            rem_r    <= ZERO;
            quo_r    <= ZERO;
            div_r    <= ZERO;
        end else if (flush) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r   <= op;
                        word_r <= word_s;
                        neg_r  <= neg_s;
                        cnt_r  <= 7'd0;
                        if (op[2]) begin
                            if (div_zero_s || div_ovf_s) begin
                                result_r <= bypass_s;
                                state_r  <= ST_DONE;
                            end else begin
                                rem_r   <= ZERO;
                                quo_r   <= mag1_s;
                                div_r   <= mag2_s;
                                state_r <= ST_DIV;
                            end
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            result_r <= fast_res_s;
                            state_r  <= ST_DONE;
`else
                            prod_r   <= PZERO;
                            mcand_r  <= {ZERO, mag1_s};
                            mplier_r <= mag2_s;
                            state_r  <= ST_MUL;
`endif
                        end
                    end
                end
                ST_MUL: begin
                    if (last_s) begin
                        result_r <= mul_res_s;
                        state_r  <= ST_DONE;
                    end else begin
                        prod_r   <= prod_nxt_s;
                        mcand_r  <= {mcand_r[PW-2:0], 1'b0};
                        mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
                        cnt_r    <= cnt_r + 7'd1;
                    end
                end
                ST_DIV: begin
                    if (last_s) begin
                        result_r <= div_res_s;
                        state_r  <= ST_DONE;
                    end else begin
                        rem_r <= rem_nxt_s;
                        quo_r <= {quo_r[XLEN-2:0], take_s};
                        cnt_r <= cnt_r + 7'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state_r <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_r == ST_IDLE) & ~rst;
    assign out_valid = (state_r == ST_DONE);
    assign result    = result_r;

endmodule
